// File: rtl/rom_load_pkg.sv
// rom_load_pkg
//   Shared types and constants for the ROM/cartridge load arbiter.
//   - state_t   : arbiter FSM states
//   - IDX_*     : ioctl download indices that target memory
//   - *_BASE    : memory region base addresses (19-bit memory map)
//   - CART_SLOTS: number of 16 KB cartridge slots
package rom_load_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      RD_DATA = 2'd2,
      WR      = 2'd3
   } state_t;

   localparam logic [7:0]  IDX_ROM    = 8'd0;
   localparam logic [7:0]  IDX_CART   = 8'd1;

   localparam logic [18:0] ROM_BASE   = 19'h00000;
   localparam logic [18:0] CART_BASE  = 19'h40000;

   localparam int          CART_SLOTS = 16;

endpackage

// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter
//   Shares the single-port ROM/cartridge memory between CPU reads and ioctl
//   download writes. Download bytes are buffered in a one-entry holding
//   register (ioctl_wait while it is full) and written when no CPU read is
//   pending; CPU reads always win. The CPU is held in reset during a ROM or
//   cartridge download and for SETTLE cycles afterwards.
//
// Ports
//   clk_sys, reset_n          : clock, synchronous active-low reset
//   dn_download/dn_wr/dn_addr/dn_data/dn_index : ioctl download interface
//   ioctl_wait                : stall request back to the loader
//   cartridge_select          : active slot for CPU cartridge reads
//   cpu_req/cpu_cart/cpu_addr : CPU read request (pulse, region, offset)
//   cpu_data/cpu_valid        : read data and its valid pulse
//   cpu_hold                  : CPU reset request
//   mem_addr/mem_we/mem_din   : memory port (all registered)
//   mem_dout                  : memory read data, 1-cycle latency
//   cart_loaded               : per-slot "has been written" flags
//   dn_done                   : pulse after dn_download falls
module rom_load_arbiter
   import rom_load_pkg::*;
#(
   parameter int MEM_AW = 19,
   parameter int SETTLE = 16
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dn_download,
   input  logic              dn_wr,
   input  logic [17:0]       dn_addr,
   input  logic [7:0]        dn_data,
   input  logic [7:0]        dn_index,
   output logic              ioctl_wait,
   input  logic [3:0]        cartridge_select,
   input  logic              cpu_req,
   input  logic              cpu_cart,
   input  logic [13:0]       cpu_addr,
   output logic [7:0]        cpu_data,
   output logic              cpu_valid,
   output logic              cpu_hold,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout,
   output logic [15:0]       cart_loaded,
   output logic              dn_done
);

   localparam int CNT_W = $clog2(SETTLE + 1);

   state_t              state_reg;

   // one-entry download holding register
   logic                hold_full_reg;
   logic [MEM_AW-1:0]   hold_addr_reg;
   logic [7:0]          hold_data_reg;
   logic                hold_cart_reg;
   logic [3:0]          hold_slot_reg;

   // CPU request that arrived while a write was in progress
   logic                pend_req_reg;
   logic [MEM_AW-1:0]   pend_addr_reg;

   logic [MEM_AW-1:0]   mem_addr_reg;
   logic                mem_we_reg;
   logic [7:0]          mem_din_reg;
   logic                cpu_valid_reg;
   logic [7:0]          cpu_data_reg;
   logic [15:0]         cart_loaded_reg;
   logic [15:0]         cart_set_next;

   logic                dn_download_d_reg;
   logic                dn_done_reg;
   logic                cpu_hold_reg;
   logic [CNT_W-1:0]    settle_cnt_reg;

   logic                idx_rom;
   logic                idx_cart;
   logic                dn_accept;
   logic                hold_active;
   logic [MEM_AW-1:0]   dn_map;
   logic [MEM_AW-1:0]   cpu_map;

   always_comb begin
      idx_rom     = (dn_index == IDX_ROM);
      idx_cart    = (dn_index == IDX_CART);
      // bytes for other indices are simply not captured: no wait, no write
      dn_accept   = dn_wr && !hold_full_reg && (idx_rom || idx_cart);
      hold_active = dn_download && (idx_rom || idx_cart);
      dn_map      = idx_cart ? (MEM_AW'(CART_BASE) | MEM_AW'(dn_addr))
                             : (MEM_AW'(ROM_BASE)  | MEM_AW'(dn_addr[13:0]));
      cpu_map     = cpu_cart ? (MEM_AW'(CART_BASE) | MEM_AW'({cartridge_select, cpu_addr}))
                             : (MEM_AW'(ROM_BASE)  | MEM_AW'(cpu_addr));
   end

   // slot flag set by the write being committed this cycle
   for (genvar gi = 0; gi < CART_SLOTS; gi++) begin : g_slot
      assign cart_set_next[gi] = (state_reg == WR) && hold_cart_reg &&
                                 (hold_slot_reg == 4'(gi));
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         hold_full_reg   <= 1'b0;
         hold_addr_reg   <= '0;
         hold_data_reg   <= '0;
         hold_cart_reg   <= 1'b0;
         hold_slot_reg   <= '0;
         pend_req_reg    <= 1'b0;
         pend_addr_reg   <= '0;
         mem_addr_reg    <= '0;
         mem_we_reg      <= 1'b0;
         mem_din_reg     <= '0;
         cpu_valid_reg   <= 1'b0;
         cpu_data_reg    <= '0;
         cart_loaded_reg <= '0;
      end else begin
         mem_we_reg    <= 1'b0;
         cpu_valid_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (cpu_req) begin
                  mem_addr_reg <= cpu_map;
                  state_reg    <= RD;
               end else if (pend_req_reg) begin
                  mem_addr_reg <= pend_addr_reg;
                  pend_req_reg <= 1'b0;
                  state_reg    <= RD;
               end else if (hold_full_reg) begin
                  mem_addr_reg <= hold_addr_reg;
                  mem_din_reg  <= hold_data_reg;
                  mem_we_reg   <= 1'b1;
                  state_reg    <= WR;
               end
            end

            RD: begin
               // memory samples mem_addr this cycle; data appears next cycle
               cpu_valid_reg <= 1'b1;
               state_reg     <= RD_DATA;
            end

            RD_DATA: begin
               cpu_data_reg <= mem_dout;
               if (hold_full_reg && !cpu_req) begin
                  mem_addr_reg <= hold_addr_reg;
                  mem_din_reg  <= hold_data_reg;
                  mem_we_reg   <= 1'b1;
                  state_reg    <= WR;
               end else if (cpu_req) begin
                  mem_addr_reg <= cpu_map;
                  state_reg    <= RD;
               end else begin
                  state_reg    <= IDLE;
               end
            end

            WR: begin
               hold_full_reg   <= 1'b0;
               cart_loaded_reg <= cart_loaded_reg | cart_set_next;
               if (cpu_req) begin
                  pend_req_reg  <= 1'b1;
                  pend_addr_reg <= cpu_map;
               end
               state_reg <= IDLE;
            end

            default: state_reg <= IDLE;
         endcase

         // hold_full_reg is set whenever WR is active, so capture never
         // collides with the clear above
         if (dn_accept) begin
            hold_full_reg <= 1'b1;
            hold_addr_reg <= dn_map;
            hold_data_reg <= dn_data;
            hold_cart_reg <= idx_cart;
            hold_slot_reg <= dn_addr[17:14];
         end
      end
   end

   // Download end detection and CPU hold. The counter is kept loaded while
   // the download is active, so every fall (including after a re-rise)
   // starts a full SETTLE-cycle countdown.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         dn_download_d_reg <= 1'b0;
         dn_done_reg       <= 1'b0;
         cpu_hold_reg      <= 1'b0;
         settle_cnt_reg    <= '0;
      end else begin
         dn_download_d_reg <= dn_download;
         dn_done_reg       <= dn_download_d_reg && !dn_download;
         if (hold_active) begin
            settle_cnt_reg <= CNT_W'(SETTLE);
            cpu_hold_reg   <= 1'b1;
         end else if (settle_cnt_reg != '0) begin
            settle_cnt_reg <= settle_cnt_reg - CNT_W'(1);
            cpu_hold_reg   <= 1'b1;
         end else begin
            cpu_hold_reg   <= 1'b0;
         end
      end
   end

   // Read data is passed straight from the memory during the valid cycle so
   // it lines up with cpu_valid; the register keeps the last value after.
   assign cpu_data    = cpu_valid_reg ? mem_dout : cpu_data_reg;
   assign cpu_valid   = cpu_valid_reg;
   assign ioctl_wait  = hold_full_reg;
   assign mem_addr    = mem_addr_reg;
   assign mem_we      = mem_we_reg;
   assign mem_din     = mem_din_reg;
   assign cart_loaded = cart_loaded_reg;
   assign cpu_hold    = cpu_hold_reg;
   assign dn_done     = dn_done_reg;

endmodule
